dataflow: RTL and testbench



---
 rtl/dataflow_pkg.sv | 14 +
 rtl/dataflow_gate_core.sv | 18 +
 rtl/dataflow.sv | 90 +++++++++
 tb/tb_dataflow.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dataflow_pkg.sv
// Shared constants for the dataflow basic-logic unit: result-vector bit positions.
package dataflow_pkg;

  localparam int NUM_GATES = 7;

  localparam int AND_IDX  = 0;
  localparam int OR_IDX   = 1;
  localparam int NAND_IDX = 2;
  localparam int NOR_IDX  = 3;
  localparam int XOR_IDX  = 4;
  localparam int XNOR_IDX = 5;
  localparam int NOT_IDX  = 6;

endpackage

// File: rtl/dataflow_gate_core.sv
// Purely combinational two-input gate bank; one result bit per gate, ordered by dataflow_pkg indices.
module dataflow_gate_core
  import dataflow_pkg::*;
(
  input  logic                 a,
  input  logic                 b,
  output logic [NUM_GATES-1:0] res
);

  assign res[AND_IDX]  = a & b;
  assign res[OR_IDX]   = a | b;
  assign res[NAND_IDX] = ~(a & b);
  assign res[NOR_IDX]  = ~(a | b);
  assign res[XOR_IDX]  = a ^ b;
  assign res[XNOR_IDX] = ~(a ^ b);
  assign res[NOT_IDX]  = ~a;

endmodule

// File: rtl/dataflow.sv
// Basic-logic unit: combinational gate outputs, registered snapshot and saturating input-change counter.
// Optional sticky invariant checker on the snapshot when DATAFLOW_SELF_CHECK_EN is defined.
module dataflow
  import dataflow_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a,
  input  logic                 b,
  input  logic                 cnt_clr,
  output logic                 out_and,
  output logic                 out_or,
  output logic                 out_nand,
  output logic                 out_nor,
  output logic                 out_xor,
  output logic                 out_xnor,
  output logic                 out_not,
  output logic [NUM_GATES-1:0] out_q,
  output logic [CNT_W-1:0]     chg_cnt
`ifdef DATAFLOW_SELF_CHECK_EN
  ,
  output logic                 chk_err
`endif
);

  logic [NUM_GATES-1:0] res;
  logic                 a_q;
  logic                 b_q;
  logic                 changed;

  dataflow_gate_core u_core (
    .a   (a),
    .b   (b),
    .res (res)
  );

  // Combinational outputs bypass the clock/reset domain entirely.
  assign out_and  = res[AND_IDX];
  assign out_or   = res[OR_IDX];
  assign out_nand = res[NAND_IDX];
  assign out_nor  = res[NOR_IDX];
  assign out_xor  = res[XOR_IDX];
  assign out_xnor = res[XNOR_IDX];
  assign out_not  = res[NOT_IDX];

  assign changed = ({a, b} != {a_q, b_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= 1'b0;
      b_q   <= 1'b0;
      out_q <= '0;
    end else begin
      a_q   <= a;
      b_q   <= b;
      out_q <= res;
    end
  end

  // Clear wins over increment; increment holds at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg_cnt <= '0;
    end else if (cnt_clr) begin
      chg_cnt <= '0;
    end else if (changed && (chg_cnt != {CNT_W{1'b1}})) begin
      chg_cnt <= chg_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef DATAFLOW_SELF_CHECK_EN
  logic violation;

  assign violation = (out_q[NAND_IDX] != ~out_q[AND_IDX]) |
                     (out_q[NOR_IDX]  != ~out_q[OR_IDX])  |
                     (out_q[XNOR_IDX] != ~out_q[XOR_IDX]) |
                     (out_q[XOR_IDX]  != (out_q[AND_IDX] ^ out_q[OR_IDX]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err <= 1'b0;
    end else if (violation) begin
      chk_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dataflow.sv
// Scoreboard bench for dataflow: driver pushes reference results, monitor pops and compares each clock.
module tb_dataflow;
  import dataflow_pkg::*;

  logic clk = 1'b0;
  bit   clk_run = 1'b0;
  logic rst_n = 1'b0;
  logic a = 1'b0, b = 1'b0, cnt_clr = 1'b0;

  logic       and8, or8, nand8, nor8, xor8, xnor8, not8;
  logic       and2, or2, nand2, nor2, xor2, xnor2, not2;
  logic [6:0] q8, q2;
  logic [7:0] c8;
  logic [1:0] c2;
  logic [6:0] comb8, comb2;
`ifdef DATAFLOW_SELF_CHECK_EN
  logic       e8, e2;
`endif

  always #5 if (clk_run) clk = ~clk;

  dataflow #(.CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cnt_clr(cnt_clr),
    .out_and(and8), .out_or(or8), .out_nand(nand8), .out_nor(nor8),
    .out_xor(xor8), .out_xnor(xnor8), .out_not(not8),
    .out_q(q8), .chg_cnt(c8)
`ifdef DATAFLOW_SELF_CHECK_EN
    , .chk_err(e8)
`endif
  );

  dataflow #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cnt_clr(cnt_clr),
    .out_and(and2), .out_or(or2), .out_nand(nand2), .out_nor(nor2),
    .out_xor(xor2), .out_xnor(xnor2), .out_not(not2),
    .out_q(q2), .chg_cnt(c2)
`ifdef DATAFLOW_SELF_CHECK_EN
    , .chk_err(e2)
`endif
  );

  always_comb begin
    comb8 = '0;
    comb8[AND_IDX] = and8;  comb8[OR_IDX] = or8;    comb8[NAND_IDX] = nand8;
    comb8[NOR_IDX] = nor8;  comb8[XOR_IDX] = xor8;  comb8[XNOR_IDX] = xnor8;
    comb8[NOT_IDX] = not8;
    comb2 = '0;
    comb2[AND_IDX] = and2;  comb2[OR_IDX] = or2;    comb2[NAND_IDX] = nand2;
    comb2[NOR_IDX] = nor2;  comb2[XOR_IDX] = xor2;  comb2[XNOR_IDX] = xnor2;
    comb2[NOT_IDX] = not2;
  end

  typedef struct packed {
    logic       a;
    logic       b;
    logic [6:0] q;
    logic [7:0] c8;
    logic [1:0] c2;
  } exp_t;

  exp_t sb[$];
  int   errs = 0;
  int   checks = 0;

  // Reference model state: counts kept as plain integers, saturated by comparison.
  int         m_cnt8 = 0;
  int         m_cnt2 = 0;
  logic [1:0] m_prev = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Gate results from the count of ones on the inputs.
  function automatic logic [6:0] ref_gates(input logic x, input logic y);
    int s;
    logic [6:0] r;
    s = int'(x) + int'(y);
    r = '0;
    r[AND_IDX]  = (s == 2);
    r[OR_IDX]   = (s >= 1);
    r[NAND_IDX] = (s != 2);
    r[NOR_IDX]  = (s == 0);
    r[XOR_IDX]  = (s == 1);
    r[XNOR_IDX] = (s != 1);
    r[NOT_IDX]  = (x == 1'b0);
    return r;
  endfunction

  task automatic model_reset();
    m_cnt8 = 0;
    m_cnt2 = 0;
    m_prev = 2'b00;
  endtask

  task automatic drive(input logic x, input logic y, input logic clr);
    exp_t e;
    @(negedge clk);
    a = x; b = y; cnt_clr = clr;
    if (clr) begin
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else if ({x, y} != m_prev) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    m_prev = {x, y};
    e.a = x; e.b = y;
    e.q = ref_gates(x, y);
    e.c8 = 8'(m_cnt8);
    e.c2 = 2'(m_cnt2);
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #2;
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_comb8"}, comb8, ref_gates(a, b));
    chk({tag, "_comb2"}, comb2, ref_gates(a, b));
    chk({tag, "_q8"}, q8, 0);
    chk({tag, "_c8"}, c8, 0);
    chk({tag, "_c2"}, c2, 0);
  endtask

  // Monitor: outputs are presented every clock; compare whenever an expectation is queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("comb8", comb8, e.q);
        chk("comb2", comb2, e.q);
        chk("out_q8", q8, e.q);
        chk("out_q2", q2, e.q);
        chk("chg_cnt8", c8, e.c8);
        chk("chg_cnt2", c2, e.c2);
`ifdef DATAFLOW_SELF_CHECK_EN
        chk("chk_err8", e8, 0);
        chk("chk_err2", e2, 0);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    // Reset held, clock idle: combinational path must still follow the inputs.
    for (int i = 0; i < 4; i++) begin
      a = i[1]; b = i[0];
      #1;
      check_idle("idle");
    end
    a = 1'b0; b = 1'b0;
    #1 rst_n = 1'b1;
    #1 clk_run = 1'b1;

    drive(0, 0, 0);
    drive(0, 1, 0);
    drive(1, 0, 0);
    drive(1, 1, 0);
    @(posedge clk); #1;
    chk("out_q_11", q8, 7'b0100011);
    chk("cnt_after_seq", c8, 3);
    repeat (5) drive(1, 1, 0);
    for (int i = 0; i < 6; i++) drive(i[0], 1, 0);
    drive(0, 0, 1);

    for (int i = 0; i < 300; i++)
      drive(1'($urandom), 1'($urandom), ($urandom_range(15) == 0));
    drain();

    // Reset mid-operation with nonzero inputs and a running clock.
    @(negedge clk);
    a = 1'b1; b = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_idle("midrst");
    @(posedge clk); #1;
    check_idle("midrst_edge");
    @(negedge clk);
    a = 1'b0; b = 1'b0;
    rst_n = 1'b1;
    model_reset();

    drive(1, 1, 0);
    for (int i = 0; i < 100; i++)
      drive(1'($urandom), 1'($urandom), ($urandom_range(15) == 0));
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
